alu_arbiter: RTL and testbench

- Shares the single combinational ALU (8-bit operands, 3-bit Aluop, shift/shiftDirection, result/equal/lessThan outputs) between NUM_REQ requesters, e.g. the execute stage and the branch/address unit.
- Round-robin grant with a valid/ready request handshake.
- Operands are latched, the ALU is driven for one cycle, and result and flags are registered.
- Results are returned on a shared response bus, with a per-requester valid/ready handshake.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_arbiter_rr_picker.sv | 27 ++
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcodes, FSM states and the request payload.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTE = 3'b110,
    ALU_EQ   = 3'b111
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    aluop_t            aluop;
    logic              shift;
    logic              dir;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin search: first valid requester at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     ptr,
  output logic               found_c,
  output logic [IDW-1:0]     winner_c
);

  logic [IDW-1:0] idx;

  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((32'(ptr) + i) % NUM_REQ);
      if (!found_c && valid[idx]) begin
        found_c  = 1'b1;
        winner_c = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin grant.
// Flow per operation: accept (IDLE) -> drive ALU (EXEC) -> hold response (RESP).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*DATA_W-1:0] req_op2,
  input  logic [NUM_REQ*OP_W-1:0]   req_aluop,
  input  logic [NUM_REQ-1:0]        req_shift,
  input  logic [NUM_REQ-1:0]        req_dir,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_result,
  output logic                      resp_equal,
  output logic                      resp_less,
  output logic [DATA_W-1:0]         alu_op1,
  output logic [DATA_W-1:0]         alu_op2,
  output logic [OP_W-1:0]           alu_aluop,
  output logic                      alu_shift,
  output logic                      alu_dir,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_equal,
  input  logic                      alu_less
);

  arb_state_t         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, grant_q, winner;
  logic               found, accept, resp_done;
  alu_req_t           reqs [NUM_REQ];
  alu_req_t           exec_q;
  logic [DATA_W-1:0]  result_q;
  logic               equal_q, less_q;
  logic [NUM_REQ-1:0] resp_valid_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign reqs[g] = '{op1:   req_op1[DATA_W*g +: DATA_W],
                       op2:   req_op2[DATA_W*g +: DATA_W],
                       aluop: aluop_t'(req_aluop[OP_W*g +: OP_W]),
                       shift: req_shift[g],
                       dir:   req_dir[g]};
  end

  rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_picker (
    .valid    (req_valid),
    .ptr      (rr_ptr_q),
    .found_c  (found),
    .winner_c (winner)
  );

  // Next state and the same-cycle accept strobe; req_ready is forced low while in reset.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    resp_done = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          accept            = 1'b1;
          req_ready[winner] = reset_n;
          state_d           = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (resp_ready[grant_q]) begin
          resp_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      exec_q       <= '0;
      result_q     <= '0;
      equal_q      <= 1'b0;
      less_q       <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      state_q <= state_d;
      // exec_q doubles as the ALU drive, so it is only non-zero during EXEC
      if (accept) begin
        exec_q   <= reqs[winner];
        grant_q  <= winner;
        rr_ptr_q <= IDW'((32'(winner) + 32'd1) % NUM_REQ);
      end else if (state_q == EXEC) begin
        exec_q <= '0;
      end
      if (state_q == EXEC) begin
        result_q     <= alu_result;
        equal_q      <= alu_equal;
        less_q       <= alu_less;
        resp_valid_q <= NUM_REQ'(1) << grant_q;
      end
      if (resp_done) begin
        resp_valid_q <= '0;
      end
    end
  end

  assign alu_op1     = exec_q.op1;
  assign alu_op2     = exec_q.op2;
  assign alu_aluop   = exec_q.aluop;
  assign alu_shift   = exec_q.shift;
  assign alu_dir     = exec_q.dir;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_equal  = equal_q;
  assign resp_less   = less_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors, corner sequences and a
// random run against a transaction-level reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned N = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid, req_ready, req_shift, req_dir;
  logic [N*8-1:0]   req_op1, req_op2;
  logic [N*3-1:0]   req_aluop;
  logic [N-1:0]     resp_valid, resp_ready;
  logic [7:0]       resp_result, alu_op1, alu_op2, alu_result;
  logic             resp_equal, resp_less, alu_shift, alu_dir, alu_equal, alu_less;
  logic [2:0]       alu_aluop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_aluop(req_aluop),
    .req_shift(req_shift), .req_dir(req_dir),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_equal(resp_equal), .resp_less(resp_less),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_aluop(alu_aluop),
    .alu_shift(alu_shift), .alu_dir(alu_dir),
    .alu_result(alu_result), .alu_equal(alu_equal), .alu_less(alu_less)
  );

  typedef struct packed { logic [7:0] r; logic eq; logic lt; } alu_out_t;

  // Behavioural ALU seen by the arbiter
  function automatic alu_out_t alu_f(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] op, input logic sh, input logic dir);
    alu_out_t o;
    case (op)
      ALU_AND: o.r = a & b;
      ALU_OR:  o.r = a | b;
      ALU_XOR: o.r = a ^ b;
      ALU_ADD: o.r = a + b;
      ALU_SUB: o.r = a - b;
      default: o.r = 8'h00;
    endcase
    if (sh) o.r = dir ? (a >> b[2:0]) : (a << b[2:0]);
    o.eq = (a == b);
    o.lt = (op == ALU_SLTE) ? (a <= b) : (a < b);
    return o;
  endfunction

  alu_out_t alu_o;
  assign alu_o      = alu_f(alu_op1, alu_op2, alu_aluop, alu_shift, alu_dir);
  assign alu_result = alu_o.r;
  assign alu_equal  = alu_o.eq;
  assign alu_less   = alu_o.lt;

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] op;
    logic       sh, dir;
    logic [7:0] r;
    logic       eq, lt;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic sh, input logic dir);
    req_valid[i]      = 1'b1;
    req_op1[8*i +: 8] = a;
    req_op2[8*i +: 8] = b;
    req_aluop[3*i +: 3] = op;
    req_shift[i]      = sh;
    req_dir[i]        = dir;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [63:0] all_outs();
    return {req_ready, resp_valid, resp_result, resp_equal, resp_less,
            alu_op1, alu_op2, alu_aluop, alu_shift, alu_dir};
  endfunction

  task automatic run_vec(input int i, input vec_t v, input int k);
    @(negedge clk);
    set_req(i, v.a, v.b, v.op, v.sh, v.dir);
    #1 check($sformatf("vec%0d_ready", k), req_ready, N'(1) << i);
    @(negedge clk);
    req_valid[i] = 1'b0;
    #1 check($sformatf("vec%0d_alu", k), {alu_op1, alu_op2, alu_aluop, alu_shift, alu_dir},
             {v.a, v.b, v.op, v.sh, v.dir});
    @(negedge clk);
    #1 check($sformatf("vec%0d_resp", k), {resp_valid, resp_result, resp_equal, resp_less},
             {N'(1) << i, v.r, v.eq, v.lt});
  endtask

  // Reference model state for the random run
  logic       pend [N];
  logic [7:0] pa [N], pb [N];
  logic [2:0] pop [N];
  logic       psh [N], pdir [N];

  task automatic random_run(input int cycles);
    int         ptr, phase, gnt, w, c;
    logic [7:0] ca, cb;
    logic [2:0] cop;
    logic       csh, cdir;
    alu_out_t   eo;
    logic [N-1:0] exp_ready;
    ptr = 0; phase = 0; gnt = 0;
    ca = '0; cb = '0; cop = '0; csh = 1'b0; cdir = 1'b0; eo = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i]   = 8'($urandom);
          pb[i]   = ($urandom_range(0, 3) == 0) ? pa[i] : 8'($urandom);
          pop[i]  = 3'($urandom);
          psh[i]  = ($urandom_range(0, 3) == 0);
          pdir[i] = 1'($urandom);
        end
        if (pend[i]) set_req(i, pa[i], pb[i], pop[i], psh[i], pdir[i]);
        else begin
          req_valid[i]      = 1'b0;
          req_op1[8*i +: 8] = 8'($urandom);
        end
      end
      resp_ready = N'($urandom);
      #1;
      w = -1;
      exp_ready = '0;
      if (phase == 0) begin
        for (int j = 0; j < N; j++) begin
          c = (ptr + j) % N;
          if (w < 0 && pend[c]) w = c;
        end
        if (w >= 0) exp_ready = N'(1) << w;
      end
      check($sformatf("rnd%0d_ready", cyc), req_ready, exp_ready);
      if (phase == 1)
        check($sformatf("rnd%0d_alu", cyc), {alu_op1, alu_op2, alu_aluop, alu_shift, alu_dir},
              {ca, cb, cop, csh, cdir});
      else
        check($sformatf("rnd%0d_alu_idle", cyc), {alu_op1, alu_op2, alu_aluop, alu_shift, alu_dir}, 0);
      if (phase == 2)
        check($sformatf("rnd%0d_resp", cyc), {resp_valid, resp_result, resp_equal, resp_less},
              {N'(1) << gnt, eo.r, eo.eq, eo.lt});
      else
        check($sformatf("rnd%0d_noresp", cyc), resp_valid, 0);
      case (phase)
        0: if (w >= 0) begin
             gnt = w; ptr = (w + 1) % N;
             ca = pa[w]; cb = pb[w]; cop = pop[w]; csh = psh[w]; cdir = pdir[w];
             eo = alu_f(ca, cb, cop, csh, cdir);
             pend[w] = 1'b0;
             phase = 1;
           end
        1: phase = 2;
        default: if (resp_ready[gnt]) phase = 0;
      endcase
    end
    req_valid = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h12, 8'h34, ALU_ADD,  1'b0, 1'b0, 8'h46, 1'b0, 1'b1};
    vecs[1]  = '{8'h05, 8'h03, ALU_SUB,  1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[2]  = '{8'hF0, 8'h0F, ALU_XOR,  1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[3]  = '{8'h03, 8'h03, ALU_SLTE, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4]  = '{8'h07, 8'h07, ALU_EQ,   1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{8'hAA, 8'h0F, ALU_AND,  1'b0, 1'b0, 8'h0A, 1'b0, 1'b0};
    vecs[6]  = '{8'h50, 8'h05, ALU_OR,   1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
    vecs[7]  = '{8'h02, 8'h09, ALU_SLT,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{8'hFF, 8'h01, ALU_ADD,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{8'h81, 8'h01, ALU_AND,  1'b1, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[10] = '{8'h81, 8'h03, ALU_AND,  1'b1, 1'b1, 8'h10, 1'b0, 1'b0};

    reset_n    = 1'b0;
    req_valid  = '1;
    req_op1    = '0; req_op2 = '0; req_aluop = '0; req_shift = '0; req_dir = '0;
    resp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    #1 check("reset_outputs", all_outs(), 0);

    // Single request: accept, EXEC, RESP, then back in IDLE with rr_ptr=1
    do_reset();
    @(negedge clk);
    set_req(0, 8'h12, 8'h34, ALU_ADD, 1'b0, 1'b0);
    #1 check("single_ready_c0", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    #1 check("single_alu_c1", {alu_op1, alu_op2, alu_aluop, req_ready}, {8'h12, 8'h34, ALU_ADD, 2'b00});
    @(negedge clk);
    #1 check("single_resp_c2", {resp_valid, resp_result}, {2'b01, 8'h46});
    @(negedge clk);
    set_req(0, 8'h01, 8'h01, ALU_OR, 1'b0, 1'b0);
    set_req(1, 8'h01, 8'h01, ALU_OR, 1'b0, 1'b0);
    #1 check("single_idle_c3", {resp_valid, alu_op1, req_ready}, {2'b00, 8'h00, 2'b10});

    // Table of vectors, alternating requesters
    do_reset();
    for (int k = 0; k < 11; k++) run_vec(k % 2, vecs[k], k);

    // Contention: both valid continuously, grants must alternate
    do_reset();
    @(negedge clk);
    set_req(0, 8'h05, 8'h03, ALU_SUB, 1'b0, 1'b0);
    set_req(1, 8'hF0, 8'h0F, ALU_XOR, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("cont%0d_grant", k), req_ready, N'(1) << (k % 2));
      @(negedge clk);
      #1 check($sformatf("cont%0d_busy", k), req_ready, 0);
      @(negedge clk);
      #1 check($sformatf("cont%0d_resp", k), {resp_valid, resp_result},
               {N'(1) << (k % 2), (k % 2 == 1) ? 8'hFF : 8'h02});
      @(negedge clk);
    end
    req_valid = '0;

    // Backpressure on requester 1 while requester 0 waits
    do_reset();
    @(negedge clk);
    resp_ready = 2'b01;
    set_req(1, 8'h07, 8'h07, ALU_EQ, 1'b0, 1'b0);
    #1 check("bp_grant1", req_ready, 2'b10);
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_req(0, 8'h01, 8'h01, ALU_ADD, 1'b0, 1'b0);
    #1 check("bp_exec_noready", req_ready, 2'b00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 check($sformatf("bp_hold%0d", c), {resp_valid, resp_equal, resp_less, resp_result, req_ready},
               {2'b10, 1'b1, 1'b0, 8'h00, 2'b00});
    end
    resp_ready = 2'b10;
    @(negedge clk);
    #1 check("bp_after_hs", {req_ready, resp_valid, resp_equal}, {2'b01, 2'b00, 1'b1});
    @(negedge clk);
    req_valid = '0;
    #1 check("bp_req0_exec", alu_op1, 8'h01);
    @(negedge clk);
    #1 check("bp_req0_resp", {resp_valid, resp_result}, {2'b01, 8'h02});

    // Operand hold: payload changes after accept are ignored
    do_reset();
    @(negedge clk);
    set_req(0, 8'h33, 8'h01, ALU_ADD, 1'b0, 1'b0);
    #1 check("hold_ready", req_ready, 2'b01);
    @(negedge clk);
    req_op1[7:0] = 8'hCC;
    req_op2[7:0] = 8'h55;
    req_valid    = '0;
    #1 check("hold_alu_op1", {alu_op1, alu_op2}, {8'h33, 8'h01});
    @(negedge clk);
    #1 check("hold_result", resp_result, 8'h34);

    // Reset during EXEC of a requester-1 operation
    do_reset();
    @(negedge clk);
    set_req(0, 8'h01, 8'h02, ALU_ADD, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    set_req(0, 8'h11, 8'h22, ALU_ADD, 1'b0, 1'b0);
    set_req(1, 8'h44, 8'h55, ALU_OR,  1'b0, 1'b0);
    #1 check("rst_pre_grant1", req_ready, 2'b10);
    @(negedge clk);
    #1 check("rst_pre_exec", alu_op1, 8'h44);
    reset_n = 1'b0;
    #1 check("rst_async_outputs", all_outs(), 0);
    @(negedge clk);
    reset_n      = 1'b1;
    req_valid[1] = 1'b0;
    #1 check("rst_first_grant0", req_ready, 2'b01);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1 check($sformatf("rst_no_resp1_%0d", c), resp_valid[1], 1'b0);
    end

    // Random traffic against the reference model
    do_reset();
    random_run(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
